// File: rtl/ask_mod.sv
// ask_mod: on-off keyed carrier modulator.
// A one-entry holding register accepts bits through a valid/ready handshake.
// Each held bit is sent as a symbol that lasts SYM_LEN clocks. A '1' symbol
// drives a sine carrier taken from a 16-entry table. A '0' symbol drives
// silence. The carrier phase never restarts, so the phase stays continuous
// across symbols and across idle gaps.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   din       in   data bit (1 = carrier on, 0 = carrier off)
//   din_valid in   din is valid this cycle
//   din_ready out  holding register is empty (comes from a register only)
//   dout      out  signed 8-bit registered ASK sample
//   busy      out  a symbol is being transmitted
module ask_mod #(
    parameter int SYM_LEN    = 64,
    parameter int PHASE_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic signed [7:0] dout,
    output logic              busy
);
    localparam int CW = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(SYM_LEN - 1);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_hold_bit, r_hold_full, r_cur_bit;
    logic [CW-1:0]     r_sym_cnt, w_cnt_nxt;
    logic [3:0]        r_phase;
    logic              w_accept, w_unload;

    // Amplitude is held at +/-127 so that -128 never appears.
    function automatic logic signed [7:0] sine_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    sine_lut = 8'sd0;
            4'd1:    sine_lut = 8'sd49;
            4'd2:    sine_lut = 8'sd90;
            4'd3:    sine_lut = 8'sd117;
            4'd4:    sine_lut = 8'sd127;
            4'd5:    sine_lut = 8'sd117;
            4'd6:    sine_lut = 8'sd90;
            4'd7:    sine_lut = 8'sd49;
            4'd8:    sine_lut = 8'sd0;
            4'd9:    sine_lut = -8'sd49;
            4'd10:   sine_lut = -8'sd90;
            4'd11:   sine_lut = -8'sd117;
            4'd12:   sine_lut = -8'sd127;
            4'd13:   sine_lut = -8'sd117;
            4'd14:   sine_lut = -8'sd90;
            default: sine_lut = -8'sd49;
        endcase
    endfunction

    assign din_ready = !r_hold_full;
    assign busy      = (r_state == S_SEND);
    // A transfer is possible only while the holding register is empty. An
    // unload needs it full, so a transfer and an unload never coincide.
    assign w_accept  = din_valid && !r_hold_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_unload    = 1'b0;
        w_cnt_nxt   = r_sym_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (r_hold_full) begin
                    w_state_nxt = S_SEND;
                    w_unload    = 1'b1;
                end
            end
            default: begin
                if (r_sym_cnt != LAST) begin
                    w_cnt_nxt = r_sym_cnt + 1'b1;
                end else begin
                    w_cnt_nxt = '0;
                    // Chain straight into the next symbol with no gap cycle.
                    if (r_hold_full) w_unload    = 1'b1;
                    else             w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_bit  <= 1'b0;
            r_hold_full <= 1'b0;
            r_cur_bit   <= 1'b0;
            r_sym_cnt   <= '0;
            r_phase     <= 4'd0;
            dout        <= 8'sd0;
        end else begin
            if (w_accept) begin
                r_hold_bit  <= din;
                r_hold_full <= 1'b1;
            end else if (w_unload) begin
                r_hold_full <= 1'b0;
            end
            if (w_unload) r_cur_bit <= r_hold_bit;
            r_sym_cnt <= w_cnt_nxt;
            // The phase runs free in both states, so the carrier stays continuous.
            r_phase   <= r_phase + 4'(PHASE_STEP);
            dout      <= (r_state == S_SEND && r_cur_bit) ? sine_lut(r_phase) : 8'sd0;
        end
    end
endmodule
